// File: rtl/audio_keys_pio.sv
// Avalon-MM input PIO for audio transport keys: 2-flop sync, per-bit debounce,
// edge capture and level irq. Define AUDIO_KEYS_DEBOUNCE_EN to build the debounce counters.
module audio_keys_lane #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic RST_VAL         = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic key,
  output logic edge_hit
);
  logic sync_q1, sync_q2, key_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1  <= RST_VAL;
      sync_q2  <= RST_VAL;
      key_prev <= RST_VAL;
    end else begin
      sync_q1  <= in_bit;
      sync_q2  <= sync_q1;
      key_prev <= key;
    end
  end

`ifdef AUDIO_KEYS_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt;

  // Counter only runs while the synced input disagrees with the accepted state,
  // so it tops out at CNT_MAX and never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key <= RST_VAL;
      cnt <= '0;
    end else if (sync_q2 == key) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      key <= sync_q2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  localparam int unused_dbc = DEBOUNCE_CYCLES;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key <= RST_VAL;
    else          key <= sync_q2;
  end
`endif

  assign edge_hit = (EDGE_TYPE == 0) ? (key & ~key_prev) :
                    (EDGE_TYPE == 1) ? (~key & key_prev) :
                                       (key ^ key_prev);
endmodule

module audio_keys_pio #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IN_RESET        = WIDTH'(4'hF)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] key_state, edge_hit, irq_mask, edge_capture, clr_bits;
  logic             wr_en, unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    audio_keys_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE),
      .RST_VAL        (IN_RESET[i])
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[i]),
      .key     (key_state[i]),
      .edge_hit(edge_hit[i])
    );
  end

  assign wr_en        = chipselect && !write_n;
  assign clr_bits     = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      // OR-ing new edges after the clear makes a same-cycle edge win over software.
      edge_capture <= (edge_capture & ~clr_bits) | edge_hit;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = 32'(key_state);
      2'd2:    readdata = 32'(irq_mask);
      2'd3:    readdata = 32'(edge_capture);
      default: readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_audio_keys_pio.sv
// Bench for audio_keys_pio: register table, latency/glitch/edge/reset sequences,
// with a falling-edge instance and an any-edge instance sharing the bus and keys.
module tb_audio_keys_pio;
`ifdef AUDIO_KEYS_DEBOUNCE_EN
  localparam int LAT = 6;
  localparam bit DB  = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DB  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata, rd_any;
  logic        irq, irq_any;

  int n_chk  = 0;
  int n_fail = 0;

  audio_keys_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IN_RESET(4'hF)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq));

  audio_keys_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IN_RESET(4'hF)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_any),
    .in_port(in_port), .irq(irq_any));

  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // src 0..3: dut register read, 4: dut irq, 7: any-edge instance capture register
  typedef struct { string name; int src; logic [31:0] exp; } exp_t;
  exp_t sb[$];

  typedef struct {
    string       name;
    bit          do_wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vec[9];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic push(input string n, input int s, input logic [31:0] e);
    exp_t x;
    x.name = n; x.src = s; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_now();
    exp_t e;
    logic [31:0] got;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.src)
        0, 1, 2, 3: begin address = 2'(e.src); #1; got = readdata; end
        4:          got = {31'b0, irq};
        7:          begin address = 2'd3; #1; got = rd_any; end
        default:    got = 'x;
      endcase
      n_chk++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, got, e.exp);
      end
    end
  endtask

  initial begin
    vec[0] = '{"rd_data_rst",  1'b0, 2'd0, 32'h0,        2'd0, 32'hF};
    vec[1] = '{"rd_addr1_rst", 1'b0, 2'd0, 32'h0,        2'd1, 32'h0};
    vec[2] = '{"rd_mask_rst",  1'b0, 2'd0, 32'h0,        2'd2, 32'h0};
    vec[3] = '{"rd_cap_rst",   1'b0, 2'd0, 32'h0,        2'd3, 32'h0};
    vec[4] = '{"wr_data_ign",  1'b1, 2'd0, 32'h0,        2'd0, 32'hF};
    vec[5] = '{"wr_addr1_ign", 1'b1, 2'd1, 32'hFFFF,     2'd1, 32'h0};
    vec[6] = '{"mask_width",   1'b1, 2'd2, 32'hFFFFFFFF, 2'd2, 32'hF};
    vec[7] = '{"mask_zero",    1'b1, 2'd2, 32'h0,        2'd2, 32'h0};
    vec[8] = '{"cap_clr_idle", 1'b1, 2'd3, 32'hF,        2'd3, 32'h0};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'h0; in_port = 4'hF;
    step(3);
    reset_n = 1'b1;
    push("irq_rst", 4, 32'h0); check_now();

    for (int i = 0; i < 9; i++) begin
      step(1);
      if (vec[i].do_wr) wr(vec[i].waddr, vec[i].wdata);
      push(vec[i].name, int'(vec[i].raddr), vec[i].exp);
      check_now();
    end

    // Step latency and capture one cycle later
    step(1); in_port = 4'hE;
    step(LAT - 1); push("lat_data_hold", 0, 32'hF); check_now();
    step(1); push("lat_data", 0, 32'hE); push("lat_cap_early", 3, 32'h0); check_now();
    step(1); push("lat_cap", 3, 32'h1); push("lat_irq_masked", 4, 32'h0);
    push("lat_any_cap", 7, 32'h1); check_now();

    // Mask raises irq, clear drops it
    step(1); wr(2'd2, 32'h1); push("irq_on_mask", 4, 32'h1); check_now();
    step(1); wr(2'd3, 32'h1); push("clr_cap", 3, 32'h0); push("clr_irq", 4, 32'h0); check_now();
    step(1); in_port = 4'hF;
    step(LAT + 1); push("rise_ignored", 3, 32'h0); push("rise_any", 7, 32'h1); check_now();
    step(1); wr(2'd3, 32'hF);
    step(1); in_port = 4'hE;
    step(LAT + 1); push("irq_edge", 4, 32'h1); check_now();
    step(1); wr(2'd2, 32'h0); push("irq_mask_off", 4, 32'h0); push("cap_kept", 3, 32'h1); check_now();
    step(1); wr(2'd3, 32'hF);
    step(1); in_port = 4'hF;
    step(LAT + 2); wr(2'd3, 32'hF);

    // 3-cycle glitch: rejected by debounce, passed straight through otherwise
    step(1); in_port = 4'hD;
    step(3); in_port = 4'hF;
    step(LAT + 3);
    push("glitch_data", 0, 32'hF);
    push("glitch_cap", 3, DB ? 32'h0 : 32'h2);
    push("glitch_any", 7, DB ? 32'h0 : 32'h2); check_now();
    step(1); wr(2'd3, 32'hF);

    // Pulse of exactly DEBOUNCE_CYCLES is accepted in both builds
    step(1); in_port = 4'hD;
    step(4); in_port = 4'hF;
    step(LAT + 3);
    push("pulse4_data", 0, 32'hF); push("pulse4_cap", 3, 32'h2); push("pulse4_any", 7, 32'h2); check_now();
    step(1); wr(2'd3, 32'hF);

    // Clear write coinciding with capture of bit 2: set wins
    step(1); in_port = 4'hB;
    step(LAT); wr(2'd3, 32'h4); push("set_wins", 3, 32'h4); check_now();
    step(1); wr(2'd3, 32'h4); push("clr_after_set", 3, 32'h0); check_now();
    step(1); in_port = 4'hF;
    step(LAT + 2); wr(2'd3, 32'hF);

    // Multi-bit step and any-edge toggling of bit 0
    step(1); in_port = 4'h5;
    step(LAT - 1); push("p5_hold", 0, 32'hF); check_now();
    step(1); push("p5_data", 0, 32'h5); check_now();
    step(1); push("p5_cap", 3, 32'hA); push("p5_any", 7, 32'hA); check_now();
    step(1); wr(2'd3, 32'hF);
    step(1); in_port = 4'h4;
    step(LAT + 1); push("b0_fall_any", 7, 32'h1); push("b0_fall_cap", 3, 32'h1); check_now();
    step(1); wr(2'd3, 32'hF);
    step(1); in_port = 4'h5;
    step(LAT + 1); push("b0_rise_any", 7, 32'h1); push("b0_rise_cap", 3, 32'h0);
    push("b0_rise_data", 0, 32'h5); check_now();

    // Reset mid-operation, keys held low through release
    step(1); wr(2'd2, 32'hF);
    step(1); in_port = 4'h4;
    step(LAT + 1); push("pre_rst_irq", 4, 32'h1); check_now();
    step(1); in_port = 4'h0;
    step(2); reset_n = 1'b0;
    push("rst_data", 0, 32'hF); push("rst_mask", 2, 32'h0); push("rst_cap", 3, 32'h0);
    push("rst_irq", 4, 32'h0); check_now();
    step(2); reset_n = 1'b1;
    step(LAT - 1); push("rel_data_hold", 0, 32'hF); push("rel_no_edge", 3, 32'h0); check_now();
    step(1); push("rel_data", 0, 32'h0); check_now();
    step(1); push("rel_cap", 3, 32'hF); push("rel_irq", 4, 32'h0); check_now();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
